// File: rtl/fp16_invsqrt_seq.sv
// Sequential fp16 inverse square root: a magic-constant seed refined by Newton-Raphson
// steps that borrow a shared external multiplier and adder, one operation per cycle.
module fp16_invsqrt_seq #(
    parameter int          ITERS = 1,
    parameter logic [15:0] MAGIC = 16'h59BB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_res,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_res
);

    typedef enum logic [2:0] {IDLE, HALF, YSQ, TERM, SUB, FIN, DONE} state_t;

    localparam logic [2:0]  LP_ITERS        = 3'(ITERS);
    localparam logic [15:0] LP_HALF         = 16'h3800;
    localparam logic [15:0] LP_THREE_HALVES = 16'h3E00;
    localparam logic [15:0] LP_QNAN         = 16'h7E00;
    localparam logic [15:0] LP_PINF         = 16'h7C00;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_xh;
    logic [15:0] r_t;
    logic [2:0]  r_count;

    logic        w_accept;
    logic        w_special;
    logic [15:0] w_specialRes;
    logic [2:0]  w_countInc;
    logic [4:0]  w_exp;
    logic [9:0]  w_man;

    assign w_exp      = in_data[14:10];
    assign w_man      = in_data[9:0];
    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_countInc = r_count + 3'd1;

    // Operands with no finite positive root bypass the iteration entirely.
    always_comb begin
        w_special    = 1'b1;
        w_specialRes = LP_QNAN;
        if (w_exp == 5'h1F && w_man != 10'd0) begin
            w_specialRes = LP_QNAN;
        end else if (w_exp == 5'h1F) begin
            w_specialRes = in_data[15] ? LP_QNAN : 16'h0000;
        end else if (w_exp == 5'd0 && w_man == 10'd0) begin
            w_specialRes = LP_PINF;
        end else if (in_data[15]) begin
            w_specialRes = LP_QNAN;
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = w_special ? DONE : HALF;
            HALF: w_nextState = YSQ;
            YSQ:  w_nextState = TERM;
            TERM: w_nextState = SUB;
            SUB:  w_nextState = FIN;
            FIN:  w_nextState = (w_countInc == LP_ITERS) ? DONE : YSQ;
            DONE: if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A special-case result is parked in r_y so DONE always presents r_y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= 16'h0000;
            r_y     <= 16'h0000;
            r_xh    <= 16'h0000;
            r_t     <= 16'h0000;
            r_count <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x     <= in_data;
                        r_y     <= w_special ? w_specialRes : (MAGIC - {1'b0, in_data[15:1]});
                        r_count <= 3'd0;
                    end
                end
                HALF: r_xh <= mul_res;
                YSQ:  r_t  <= mul_res;
                TERM: r_t  <= mul_res;
                SUB:  r_t  <= add_res;
                FIN: begin
                    r_y     <= mul_res;
                    r_count <= w_countInc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = 1'b0;
        out_data  = 16'h0000;
        mul_a     = 16'h0000;
        mul_b     = 16'h0000;
        add_a     = 16'h0000;
        add_b     = 16'h0000;
        case (r_state)
            HALF: begin
                mul_a = r_x;
                mul_b = LP_HALF;
            end
            YSQ: begin
                mul_a = r_y;
                mul_b = r_y;
            end
            TERM: begin
                mul_a = r_xh;
                mul_b = r_t;
            end
            SUB: begin
                add_a = LP_THREE_HALVES;
                add_b = {~r_t[15], r_t[14:0]};
            end
            FIN: begin
                mul_a = r_y;
                mul_b = r_t;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = r_y;
            end
            default: ;
        endcase
    end

endmodule
